// File: rtl/mux_wb_seq_if.sv
// Writeback-select handshake bundle: control/source inputs toward the mux and
// the registered write request back toward the register bank.
interface mux_wb_seq_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 6,
    parameter int SEL_W   = 4
);
    logic                     start;
    logic                     pair;
    logic [SEL_W-1:0]         sel;
    logic [NUM_SRC*WIDTH-1:0] src_bus;
    logic                     wr_ack;
    logic [WIDTH-1:0]         out;
    logic                     wr_en;
    logic                     beat;
    logic                     busy;
    logic                     done;
    logic                     sel_err;

    modport master (
        output start, pair, sel, src_bus, wr_ack,
        input  out, wr_en, beat, busy, done, sel_err
    );

    modport slave (
        input  start, pair, sel, src_bus, wr_ack,
        output out, wr_en, beat, busy, done, sel_err
    );
endinterface

// File: rtl/mux_wb_seq.sv
// Registered writeback-source select: latches a source index on start, then
// issues one (or, in pair mode, two consecutive) held write requests to the bank.
module mux_wb_seq #(
    parameter int          WIDTH   = 32,
    parameter int          NUM_SRC = 6,
    parameter int          SEL_W   = 4,
    parameter int unsigned CONST_A = 227,
    parameter int unsigned CONST_B = 0,
    parameter int unsigned CONST_C = 1
) (
    input  logic         clk,
    input  logic         reset,
    mux_wb_seq_if.slave  bus
);
    localparam int NUM_CODES = NUM_SRC + 3;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_WRITE, S_DONE} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic             pair_q;
    logic [WIDTH-1:0] out_q;
    logic             wr_en_q;
    logic             beat_q;
    logic             busy_q;
    logic             done_q;
    logic             sel_err_q;

    // A pair request needs both sel and sel+1 to decode, so it is rejected up front.
    function automatic logic legal(input logic [SEL_W-1:0] s, input logic p);
        int v;
        v = int'(s);
        return (v < NUM_CODES) && (!p || (v + 1 < NUM_CODES));
    endfunction

    function automatic logic [WIDTH-1:0] decode(input logic [SEL_W-1:0]         s,
                                                input logic [NUM_SRC*WIDTH-1:0] srcs);
        logic [WIDTH-1:0] val;
        int               v;
        v   = int'(s);
        val = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (v == i) val = srcs[i*WIDTH +: WIDTH];
        end
        if (v == NUM_SRC)     val = WIDTH'(CONST_A);
        if (v == NUM_SRC + 1) val = WIDTH'(CONST_B);
        if (v == NUM_SRC + 2) val = WIDTH'(CONST_C);
        return val;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            sel_q     <= '0;
            pair_q    <= 1'b0;
            out_q     <= '0;
            wr_en_q   <= 1'b0;
            beat_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (legal(bus.sel, bus.pair)) begin
                            sel_q     <= bus.sel;
                            pair_q    <= bus.pair;
                            sel_err_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state     <= S_CAPTURE;
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end
                end
                // Sources are sampled only here; out stays frozen for the whole WRITE.
                S_CAPTURE: begin
                    out_q   <= decode(sel_q, bus.src_bus);
                    wr_en_q <= 1'b1;
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (bus.wr_ack) begin
                        wr_en_q <= 1'b0;
                        if (pair_q && !beat_q) begin
                            sel_q  <= sel_q + SEL_W'(1);
                            beat_q <= 1'b1;
                            state  <= S_CAPTURE;
                        end else begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    beat_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.out     = out_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.beat    = beat_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_mux_wb_seq.sv
// Bench for mux_wb_seq: directed scenarios plus randomized transactions scored
// against a table-driven model of source selection and write sequencing.
module tb_mux_wb_seq;
    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 6;
    localparam int SEL_W   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_wb_seq_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

    mux_wb_seq #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
        .CONST_A(227), .CONST_B(0), .CONST_C(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] src_words [NUM_SRC];
    logic [WIDTH-1:0] consts    [3];

    task automatic pack_src();
        for (int i = 0; i < NUM_SRC; i++) bus.src_bus[i*WIDTH +: WIDTH] = src_words[i];
    endtask

    function automatic logic [WIDTH-1:0] ref_val(input int s);
        if (s < NUM_SRC) return src_words[s];
        return consts[s - NUM_SRC];
    endfunction

    function automatic bit ref_legal(input int s, input bit p);
        return (s <= NUM_SRC + 2) && (!p || (s + 1 <= NUM_SRC + 2));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse and services the write handshake with a fixed ack delay.
    task automatic run_txn(input int s, input bit p, input int delay, input bit disturb,
                           input int max_cyc,
                           output logic [WIDTH-1:0] v0, output logic [WIDTH-1:0] v1,
                           output int n_wr, output int n_acc, output int n_done,
                           output int n_unstable, output int n_beat_err);
        int               wait_cnt;
        logic [WIDTH-1:0] held;
        bit               held_valid;
        bit               disturbed;
        wait_cnt = 0; held = '0; held_valid = 0; disturbed = 0;
        v0 = '0; v1 = '0;
        n_wr = 0; n_acc = 0; n_done = 0; n_unstable = 0; n_beat_err = 0;
        bus.start  = 1'b1;
        bus.sel    = SEL_W'(s);
        bus.pair   = p;
        bus.wr_ack = 1'b0;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            bus.start  = 1'b0;
            bus.wr_ack = 1'b0;
            if (bus.done) begin
                n_done++;
                break;
            end
            if (bus.wr_en) begin
                n_wr++;
                if (bus.beat !== (n_acc != 0)) n_beat_err++;
                if (!held_valid) begin
                    held       = bus.out;
                    held_valid = 1;
                end else if (bus.out !== held) begin
                    n_unstable++;
                end
                if (disturb && !disturbed) begin
                    disturbed    = 1;
                    bus.start    = 1'b1;
                    bus.sel      = SEL_W'((s + 2) % NUM_SRC);
                    bus.pair     = 1'b0;
                    src_words[s] = ~src_words[s];
                    pack_src();
                end
                if (wait_cnt >= delay) begin
                    bus.wr_ack = 1'b1;
                    if (n_acc == 0) v0 = bus.out;
                    else            v1 = bus.out;
                    n_acc++;
                    wait_cnt   = 0;
                    held_valid = 0;
                end else begin
                    wait_cnt++;
                end
            end
            step();
        end
        bus.start  = 1'b0;
        bus.wr_ack = 1'b0;
    endtask

    task automatic test_reset();
        int bad_wr;
        reset = 1'b0;
        #12;
        checks++;
        if ({bus.out, bus.wr_en, bus.beat, bus.busy, bus.done, bus.sel_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: got out=%0h flags=%b required all zero", bus.out,
                     {bus.wr_en, bus.beat, bus.busy, bus.done, bus.sel_err});
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        src_words[0] = $urandom;
        pack_src();
        bus.start = 1'b1; bus.sel = '0; bus.pair = 1'b0; bus.wr_ack = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.wr_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_write: got wr_en=%b required 1", bus.wr_en);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.out, bus.wr_en, bus.beat, bus.busy, bus.done, bus.sel_err} !== '0) begin
            errors++;
            $display("FAIL reset_async_abort: got out=%0h flags=%b required all zero", bus.out,
                     {bus.wr_en, bus.beat, bus.busy, bus.done, bus.sel_err});
        end
        #2 reset = 1'b1;
        bad_wr = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) bad_wr++;
        end
        checks++;
        if (bad_wr != 0) begin
            errors++;
            $display("FAIL reset_no_wr_after: got %0d active cycles required 0", bad_wr);
        end
    endtask

    task automatic test_single_latency();
        src_words[1] = 32'hDEADBEEF;
        pack_src();
        bus.wr_ack = 1'b1;
        bus.start = 1'b1; bus.sel = SEL_W'(1); bus.pair = 1'b0;
        step();
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.wr_en, bus.done} !== 3'b100) begin
            errors++;
            $display("FAIL lat_n1: got busy/wr_en/done=%b required 100",
                     {bus.busy, bus.wr_en, bus.done});
        end
        step();
        checks++;
        if ({bus.busy, bus.wr_en, bus.done} !== 3'b110 || bus.out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lat_n2: got busy/wr_en/done=%b out=%0h required 110 out=deadbeef",
                     {bus.busy, bus.wr_en, bus.done}, bus.out);
        end
        step();
        checks++;
        if ({bus.busy, bus.wr_en, bus.done} !== 3'b001) begin
            errors++;
            $display("FAIL lat_n3: got busy/wr_en/done=%b required 001",
                     {bus.busy, bus.wr_en, bus.done});
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lat_n4_hold: got done=%b out=%0h required 0 deadbeef", bus.done, bus.out);
        end
        bus.wr_ack = 1'b0;
    endtask

    task automatic test_constants();
        logic [WIDTH-1:0] v0, v1;
        int n_wr, n_acc, n_done, n_unst, n_berr;
        for (int k = 0; k < 3; k++) begin
            run_txn(NUM_SRC + k, 0, $urandom_range(0, 2), 0, 20,
                    v0, v1, n_wr, n_acc, n_done, n_unst, n_berr);
            checks++;
            if (v0 !== consts[k] || n_acc != 1 || n_done != 1) begin
                errors++;
                $display("FAIL const_%0d: got out=%0h beats=%0d done=%0d required %0h 1 1",
                         k, v0, n_acc, n_done, consts[k]);
            end
            step();
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL const_%0d_pulse: got done=%b required 0", k, bus.done);
            end
        end
    endtask

    task automatic test_pair();
        logic [WIDTH-1:0] v0, v1;
        int n_wr, n_acc, n_done, n_unst, n_berr;
        src_words[2] = 32'h11;
        src_words[3] = 32'h22;
        pack_src();
        run_txn(2, 1, 3, 0, 40, v0, v1, n_wr, n_acc, n_done, n_unst, n_berr);
        checks++;
        if (v0 !== 32'h11 || v1 !== 32'h22) begin
            errors++;
            $display("FAIL pair_data: got %0h,%0h required 11,22", v0, v1);
        end
        checks++;
        if (n_acc != 2 || n_done != 1 || n_wr != 8) begin
            errors++;
            $display("FAIL pair_count: got beats=%0d done=%0d wr_cycles=%0d required 2 1 8",
                     n_acc, n_done, n_wr);
        end
        checks++;
        if (n_unst != 0 || n_berr != 0) begin
            errors++;
            $display("FAIL pair_hold: got unstable=%0d beat_err=%0d required 0 0", n_unst, n_berr);
        end
        step();
    endtask

    task automatic test_illegal();
        logic [WIDTH-1:0] v0, v1;
        int n_wr, n_acc, n_done, n_unst, n_berr;
        run_txn(NUM_SRC + 3, 0, 0, 0, 5, v0, v1, n_wr, n_acc, n_done, n_unst, n_berr);
        checks++;
        if (bus.sel_err !== 1'b1 || bus.busy !== 1'b0 || n_wr != 0 || n_done != 0) begin
            errors++;
            $display("FAIL illegal_sel: got sel_err=%b busy=%b wr=%0d done=%0d required 1 0 0 0",
                     bus.sel_err, bus.busy, n_wr, n_done);
        end
        src_words[4] = $urandom;
        pack_src();
        run_txn(4, 0, 0, 0, 20, v0, v1, n_wr, n_acc, n_done, n_unst, n_berr);
        checks++;
        if (bus.sel_err !== 1'b0 || n_done != 1 || v0 !== src_words[4]) begin
            errors++;
            $display("FAIL illegal_clear: got sel_err=%b done=%0d out=%0h required 0 1 %0h",
                     bus.sel_err, n_done, v0, src_words[4]);
        end
        step();
        run_txn(NUM_SRC + 2, 1, 0, 0, 5, v0, v1, n_wr, n_acc, n_done, n_unst, n_berr);
        checks++;
        if (bus.sel_err !== 1'b1 || n_wr != 0 || n_done != 0) begin
            errors++;
            $display("FAIL illegal_pair: got sel_err=%b wr=%0d done=%0d required 1 0 0",
                     bus.sel_err, n_wr, n_done);
        end
    endtask

    task automatic test_busy_ignore();
        logic [WIDTH-1:0] v0, v1, expv;
        int n_wr, n_acc, n_done, n_unst, n_berr, extra;
        src_words[1] = $urandom;
        pack_src();
        expv = src_words[1];
        run_txn(1, 0, 2, 1, 30, v0, v1, n_wr, n_acc, n_done, n_unst, n_berr);
        checks++;
        if (v0 !== expv || n_unst != 0 || n_acc != 1 || n_done != 1) begin
            errors++;
            $display("FAIL busy_ignore: got out=%0h unstable=%0d beats=%0d done=%0d required %0h 0 1 1",
                     v0, n_unst, n_acc, n_done, expv);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.done || bus.busy || bus.wr_en) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL busy_ignore_after: got %0d active cycles required 0", extra);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] v0, v1;
        int n_wr, n_acc, n_done, n_unst, n_berr;
        int s, d;
        bit p;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NUM_SRC; i++) src_words[i] = $urandom;
            pack_src();
            s = $urandom_range(0, (1 << SEL_W) - 1);
            p = 1'($urandom_range(0, 1));
            d = $urandom_range(0, 3);
            if (ref_legal(s, p)) begin
                run_txn(s, p, d, 0, 60, v0, v1, n_wr, n_acc, n_done, n_unst, n_berr);
                checks++;
                if (v0 !== ref_val(s) || (p && v1 !== ref_val(s + 1))) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: sel=%0d pair=%b got %0h,%0h required %0h,%0h",
                             t, s, p, v0, v1, ref_val(s), p ? ref_val(s + 1) : '0);
                end
                checks++;
                if (n_acc != (p ? 2 : 1) || n_done != 1 || n_unst != 0 || n_berr != 0 ||
                    bus.sel_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_seq[%0d]: got beats=%0d done=%0d unst=%0d berr=%0d err=%b required %0d 1 0 0 0",
                             t, n_acc, n_done, n_unst, n_berr, bus.sel_err, p ? 2 : 1);
                end
                step();
            end else begin
                run_txn(s, p, d, 0, 4, v0, v1, n_wr, n_acc, n_done, n_unst, n_berr);
                checks++;
                if (n_wr != 0 || n_done != 0 || bus.sel_err !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_illegal[%0d]: sel=%0d pair=%b got wr=%0d done=%0d err=%b required 0 0 1",
                             t, s, p, n_wr, n_done, bus.sel_err);
                end
            end
        end
    endtask

    initial begin
        consts[0] = 32'd227;
        consts[1] = 32'd0;
        consts[2] = 32'd1;
        for (int i = 0; i < NUM_SRC; i++) src_words[i] = '0;
        bus.start  = 1'b0;
        bus.pair   = 1'b0;
        bus.sel    = '0;
        bus.wr_ack = 1'b0;
        pack_src();
        test_reset();
        test_single_latency();
        test_constants();
        test_pair();
        test_illegal();
        test_busy_ignore();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mux_wb_seq.md
Name: mux_wb_seq

Overview:
- Parametrised, registered successor to the writeback-source select mux of the multicycle datapath.
- Selects one of NUM_SRC packed sources, or one of three parameterised constants, and latches the choice on a start pulse from the control unit.
- Drives a registered write request to the register bank and holds it until the bank acknowledges.
- Pair mode writes two consecutive sources (e.g. Hi then Lo) in one transaction.
- Flags illegal selects instead of leaving the output stale.

Parameters:
- WIDTH, 32, data width of every source and of out.
- NUM_SRC, 6, number of packed external sources in src_bus.
- SEL_W, 4, select width; SEL_W must be at least clog2(NUM_SRC+3).
- CONST_A, 227, constant returned for sel == NUM_SRC.
- CONST_B, 0, constant returned for sel == NUM_SRC+1.
- CONST_C, 1, constant returned for sel == NUM_SRC+2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a writeback transaction.
- pair  input  1  sampled with start; 1 = two-beat write (sel, then sel+1).
- sel  input  SEL_W  source index, sampled with start.
- src_bus  input  NUM_SRC*WIDTH  packed sources; source i occupies bits [i*WIDTH +: WIDTH].
- wr_ack  input  1  register bank accepted the current beat.
- out  output  WIDTH  registered write data.
- wr_en  output  1  write request, held until wr_ack.
- beat  output  1  0 = first beat, 1 = second beat of a pair.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse when a transaction completes.
- sel_err  output  1  sticky illegal-select flag; cleared by the next accepted start.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; out=0, wr_en=0, beat=0, busy=0, done=0, sel_err=0. Reset asserted mid-transaction aborts it immediately and no further wr_en is issued.
- Decode (combinational, internal): sel < NUM_SRC selects src_bus slice; NUM_SRC selects CONST_A; NUM_SRC+1 selects CONST_B; NUM_SRC+2 selects CONST_C; any higher value is illegal.
- IDLE:
  - start=1 with a legal sel: latch sel and pair, clear sel_err, go to CAPTURE; busy=1 from the next cycle.
  - start=1 with an illegal sel: set sel_err=1, stay in IDLE, no wr_en, no done.
  - In pair mode, sel+1 must also be legal; otherwise treat the request as illegal and reject it at start.
- CAPTURE (1 cycle): out <= decoded value of the latched sel; go to WRITE.
- WRITE:
  - wr_en=1, data stable on out.
  - wr_ack in the same cycle wr_en is seen completes the beat.
  - wr_ack=0 keeps wr_en=1 and out unchanged, indefinitely.
- Beat completion:
  - Single mode: go to DONE.
  - Pair mode, beat 0: latched sel increments, beat <= 1, return to CAPTURE.
- DONE (1 cycle): done=1, busy=0, wr_en=0, beat<=0; return to IDLE.
- Latency: start at edge N gives wr_en=1 at N+2. With immediate ack, done=1 at N+3 (single) or N+5 (pair).
- start while busy: ignored; no error, latched sel/pair unchanged.
- wr_ack outside WRITE: ignored.
- Sources are sampled only in CAPTURE; src_bus changes during WRITE do not affect out.
- out holds its last value after DONE until the next CAPTURE.

Test Plan:
1. Reset low mid-WRITE with wr_ack=0 -> all outputs 0 asynchronously, state IDLE; after release no wr_en until a new start.
2. start, sel=1, pair=0, src1=0xDEADBEEF, wr_ack tied 1 -> out=0xDEADBEEF with wr_en=1 at N+2; done pulse at N+3; busy high exactly N+1..N+2.
3. sel=NUM_SRC (6), then NUM_SRC+1, then NUM_SRC+2 -> out = 227, then 0, then 1, each with one done pulse.
4. pair=1, sel=2, src2=0x11, src3=0x22, wr_ack delayed 3 cycles per beat -> beat 0 out=0x11 held through the wait; beat 1 out=0x22; exactly two wr_ack-accepted beats, then done.
5. sel=NUM_SRC+3 (9) -> sel_err=1, no wr_en, no done; a subsequent legal start clears sel_err. Also pair=1 with sel=NUM_SRC+2 -> sel_err=1.
6. start re-pulsed during WRITE with a different sel, and src1 changed during WRITE -> request ignored, out unchanged, single done pulse for the original transaction.
